// File: rtl/rx_ddr_word_packer_if.sv
`default_nettype none
//==============================================================================
// Module   : rx_ddr_word_packer_if
// Purpose  : DDR3 controller user-port write request bundle (strobe/addr/data/busy).
// Revision : 1.0 - initial release
//==============================================================================
interface rx_ddr_word_packer_if;
   logic         wr_en;
   logic [24:0]  wr_addr;
   logic [255:0] wr_data;
   logic         wr_busy;

   modport master (
      output wr_en,
      output wr_addr,
      output wr_data,
      input  wr_busy
   );

   modport slave (
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      output wr_busy
   );
endinterface
`default_nettype wire

// File: rtl/rx_ddr_word_packer.sv
`default_nettype none
//==============================================================================
// Module   : rx_ddr_word_packer
// Purpose  : Packs payload bytes into 256-bit words, buffers them in a small FIFO
//            and issues linear-address write requests to the DDR3 user port.
// Revision : 1.0 - initial release
//==============================================================================
module rx_ddr_word_packer #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [24:0] ADDR_MAX   = 25'h1FFFFF
) (
   input  logic                        clk125MHz,
   input  logic                        RST,
   input  logic                        en_in,
   input  logic [7:0]                  data_in,
   rx_ddr_word_packer_if.master        ddr,
   output logic [31:0]                 frame_count,
   output logic [31:0]                 word_count,
   output logic [31:0]                 drop_count,
   output logic                        overflow
);

   localparam int              c_PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int              c_CW   = c_PW + 1;
   localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [4:0]     r_idx;
   logic [4:0]     w_idx_nxt;
   logic           w_store;
   logic           w_word_done;
   logic           w_flush_cap;
   logic           w_frame_done;

   logic [255:0]   r_shift;
   logic [255:0]   r_pend_word;
   logic           r_pend;

   logic [255:0]   r_mem [FIFO_DEPTH];
   logic [c_PW-1:0] r_wptr;
   logic [c_PW-1:0] r_rptr;
   logic [c_CW-1:0] r_cnt;
   logic           w_full;
   logic           w_pop;
   logic           w_push_ok;
   logic           w_drop;
   logic           w_issue;

   logic           r_wr_en;
   logic [24:0]    r_wr_addr;
   logic [255:0]   r_wr_data;
   logic [24:0]    r_next_addr;
   logic [31:0]    r_frame_cnt;
   logic [31:0]    r_word_cnt;
   logic [31:0]    r_drop_cnt;
   logic           r_overflow;

   //--------------------------------------------------------------------------
   // Packing FSM
   //--------------------------------------------------------------------------
   always_ff @(posedge clk125MHz) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_idx   <= 5'd0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_store      = 1'b0;
      w_word_done  = 1'b0;
      w_flush_cap  = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (en_in) begin
               w_store     = 1'b1;
               w_idx_nxt   = 5'd1;
               w_state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            if (en_in) begin
               w_store = 1'b1;
               if (r_idx == 5'd31) begin
                  w_word_done = 1'b1;
                  w_idx_nxt   = 5'd0;
               end else begin
                  w_idx_nxt = r_idx + 5'd1;
               end
            end else if (r_idx != 5'd0) begin
               w_flush_cap = 1'b1;
               w_idx_nxt   = 5'd0;
               w_state_nxt = S_FLUSH;
            end else begin
               w_frame_done = 1'b1;
               w_state_nxt  = S_IDLE;
            end
         end
         S_FLUSH: begin
            // A byte arriving here opens the next frame; it never joins the flushed word.
            w_frame_done = 1'b1;
            if (en_in) begin
               w_store     = 1'b1;
               w_idx_nxt   = 5'd1;
               w_state_nxt = S_FILL;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 5'd0;
         end
      endcase
   end

   //--------------------------------------------------------------------------
   // Word assembly: completed/partial words are staged one cycle before the FIFO
   //--------------------------------------------------------------------------
   always_ff @(posedge clk125MHz) begin
      if (RST) begin
         r_shift     <= '0;
         r_pend_word <= '0;
         r_pend      <= 1'b0;
      end else begin
         r_pend <= w_word_done | w_flush_cap;
         if (w_flush_cap) begin
            r_pend_word <= r_shift;
            r_shift     <= '0;
         end else if (w_store) begin
            if (w_word_done) begin
               r_pend_word <= {data_in, r_shift[247:0]};
               r_shift     <= '0;
            end else begin
               r_shift[{r_idx, 3'b000} +: 8] <= data_in;
            end
         end
      end
   end

   //--------------------------------------------------------------------------
   // Word FIFO; a pop in the same cycle frees the slot for a push into a full FIFO
   //--------------------------------------------------------------------------
   assign w_pop     = r_wr_en;
   assign w_full    = (r_cnt == c_FULL);
   assign w_push_ok = r_pend && (!w_full || w_pop);
   assign w_drop    = r_pend && w_full && !w_pop;
   assign w_issue   = (r_cnt != '0) && !ddr.wr_busy && !r_wr_en;

   always_ff @(posedge clk125MHz) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= r_pend_word;
      end
   end

   always_ff @(posedge clk125MHz) begin
      if (RST) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + c_PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PW'(1);
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_cnt <= r_cnt + c_CW'(1);
            2'b01:   r_cnt <= r_cnt - c_CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   //--------------------------------------------------------------------------
   // Write request port and statistics
   //--------------------------------------------------------------------------
   always_ff @(posedge clk125MHz) begin
      if (RST) begin
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_next_addr <= '0;
         r_frame_cnt <= '0;
         r_word_cnt  <= '0;
         r_drop_cnt  <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_wr_en <= w_issue;
         if (w_issue) begin
            r_wr_addr   <= r_next_addr;
            r_wr_data   <= r_mem[r_rptr];
            r_next_addr <= (r_next_addr == ADDR_MAX) ? 25'd0 : r_next_addr + 25'd1;
         end
         if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
         end
         if (r_wr_en) begin
            r_word_cnt <= r_word_cnt + 32'd1;
         end
         if (w_drop) begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
            r_overflow <= 1'b1;
         end
      end
   end

   assign ddr.wr_en    = r_wr_en;
   assign ddr.wr_addr  = r_wr_addr;
   assign ddr.wr_data  = r_wr_data;
   assign frame_count  = r_frame_cnt;
   assign word_count   = r_word_cnt;
   assign drop_count   = r_drop_cnt;
   assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rx_ddr_word_packer.sv
`default_nettype none
//==============================================================================
// Module   : tb_rx_ddr_word_packer
// Purpose  : Scoreboard bench for rx_ddr_word_packer with a frame-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_rx_ddr_word_packer;

   localparam int          FIFO_DEPTH = 4;
   localparam logic [24:0] ADDR_MAX   = 25'd3;

   logic        clk125MHz = 1'b0;
   logic        RST       = 1'b1;
   logic        en_in     = 1'b0;
   logic [7:0]  data_in   = 8'd0;
   logic [31:0] frame_count;
   logic [31:0] word_count;
   logic [31:0] drop_count;
   logic        overflow;

   rx_ddr_word_packer_if ddr ();

   rx_ddr_word_packer #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_MAX   (ADDR_MAX)
   ) dut (
      .clk125MHz   (clk125MHz),
      .RST         (RST),
      .en_in       (en_in),
      .data_in     (data_in),
      .ddr         (ddr.master),
      .frame_count (frame_count),
      .word_count  (word_count),
      .drop_count  (drop_count),
      .overflow    (overflow)
   );

   always #4 clk125MHz = ~clk125MHz;

   typedef struct packed {
      logic [24:0]  addr;
      logic [255:0] data;
   } exp_t;

   exp_t        exp_q [$];
   logic [7:0]  frm [$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          busy_mode = 0;
   logic [24:0] m_addr;
   logic [31:0] m_frames;
   logic [31:0] m_words;
   logic [31:0] m_drop;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_reset();
      m_addr   = '0;
      m_frames = '0;
      m_words  = '0;
      m_drop   = '0;
      exp_q.delete();
   endtask

   // Busy source: 0 = low, 1 = held high, 2 = random with high runs of at most 4 cycles
   initial begin
      int run;
      run = 0;
      ddr.wr_busy = 1'b0;
      forever begin
         @(negedge clk125MHz);
         case (busy_mode)
            0: ddr.wr_busy = 1'b0;
            1: ddr.wr_busy = 1'b1;
            default: begin
               if (run >= 4) begin
                  ddr.wr_busy = 1'b0;
                  run = 0;
               end else begin
                  ddr.wr_busy = ($urandom_range(0, 1) == 1);
                  run = ddr.wr_busy ? run + 1 : 0;
               end
            end
         endcase
      end
   end

   // Monitor: every strobe must match the oldest expected request
   initial begin
      logic prev_en;
      exp_t e;
      prev_en = 1'b0;
      forever begin
         @(negedge clk125MHz);
         if (ddr.wr_en === 1'b1) begin
            check("no_back_to_back", 256'(prev_en), 256'(0));
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_strobe: got addr %0h data %0h, expected no request",
                        ddr.wr_addr, ddr.wr_data);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 256'(ddr.wr_addr), 256'(e.addr));
               check("wr_data", ddr.wr_data, e.data);
            end
         end
         prev_en = ddr.wr_en;
      end
   end

   // Reference model works on the whole frame: 32-byte chunks, last one zero-padded.
   // With hold set the controller is blocked, so only FIFO_DEPTH words can be buffered.
   task automatic send_frame(input bit hold, input int gap);
      int           n;
      int           nw;
      logic [255:0] word;
      n  = frm.size();
      nw = (n + 31) / 32;
      for (int w = 0; w < nw; w++) begin
         word = '0;
         for (int b = 0; b < 32; b++) begin
            if (w * 32 + b < n) word[8 * b +: 8] = frm[w * 32 + b];
         end
         if (hold && exp_q.size() >= FIFO_DEPTH) begin
            m_drop = m_drop + 32'd1;
         end else begin
            exp_q.push_back({m_addr, word});
            m_words = m_words + 32'd1;
            m_addr  = (m_addr == ADDR_MAX) ? 25'd0 : m_addr + 25'd1;
         end
      end
      m_frames = m_frames + 32'd1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk125MHz);
         en_in   = 1'b1;
         data_in = frm[i];
      end
      for (int i = 0; i < gap; i++) begin
         @(negedge clk125MHz);
         en_in   = 1'b0;
         data_in = 8'd0;
      end
   endtask

   task automatic make_seq(input int len, input int base);
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(8'(base + i));
   endtask

   task automatic make_rand(input int len);
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(negedge clk125MHz);
         t++;
      end
      check("drain_complete", 256'(exp_q.size()), 256'(0));
      repeat (4) @(negedge clk125MHz);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_frame_count"}, 256'(frame_count), 256'(m_frames));
      check({tag, "_word_count"},  256'(word_count),  256'(m_words));
      check({tag, "_drop_count"},  256'(drop_count),  256'(m_drop));
      check({tag, "_overflow"},    256'(overflow),    256'(m_drop != 32'd0));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_wr_en"},   256'(ddr.wr_en),   256'(0));
      check({tag, "_wr_addr"}, 256'(ddr.wr_addr), 256'(0));
      check({tag, "_wr_data"}, ddr.wr_data,       256'(0));
      check_counts(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      model_reset();
      RST = 1'b1;
      repeat (3) @(negedge clk125MHz);
      RST = 1'b0;
      @(negedge clk125MHz);
      check_reset_state("reset");

      // 64 bytes 0x00..0x3F -> addresses 0,1
      make_seq(64, 0);
      send_frame(1'b0, 3);
      drain();
      check_counts("seq64");

      // Three words starting at ADDR_MAX-1 -> addresses 2,3,0
      make_rand(96);
      send_frame(1'b0, 3);
      drain();
      check_counts("wrap");

      // Short frame: only the low five bytes are non-zero
      frm.delete();
      frm.push_back(8'hAA); frm.push_back(8'hBB); frm.push_back(8'hCC);
      frm.push_back(8'hDD); frm.push_back(8'hEE);
      send_frame(1'b0, 3);
      drain();
      check_counts("short5");

      // 33 then 32 bytes with one idle cycle: new frame starts during the flush
      make_seq(33, 8'h40);
      send_frame(1'b0, 1);
      make_seq(32, 8'h80);
      send_frame(1'b0, 5);
      drain();
      check_counts("back2back");

      // Random frames with random controller back-pressure
      busy_mode = 2;
      for (int f = 0; f < 40; f++) begin
         make_rand(int'($urandom_range(1, 100)));
         send_frame(1'b0, int'($urandom_range(8, 20)));
      end
      drain();
      busy_mode = 0;
      repeat (4) @(negedge clk125MHz);
      check_counts("random");

      // Reset in the middle of a frame discards the partial word and all state
      for (int i = 0; i < 10; i++) begin
         @(negedge clk125MHz);
         en_in   = 1'b1;
         data_in = 8'(8'hC0 + i);
      end
      @(negedge clk125MHz);
      en_in = 1'b0;
      RST   = 1'b1;
      @(negedge clk125MHz);
      RST = 1'b0;
      model_reset();
      check_reset_state("midreset");
      repeat (5) @(negedge clk125MHz);
      make_rand(32);
      send_frame(1'b0, 3);
      drain();
      check_counts("after_reset");

      // Controller held busy: 6 words -> 4 buffered, 2 dropped
      busy_mode = 1;
      repeat (2) @(negedge clk125MHz);
      make_rand(192);
      send_frame(1'b1, 20);
      check("held_queue_depth", 256'(exp_q.size()), 256'(FIFO_DEPTH));
      check("held_drop_count",  256'(drop_count),   256'(m_drop));
      check("held_overflow",    256'(overflow),     256'(1));
      check("held_frame_count", 256'(frame_count),  256'(m_frames));
      busy_mode = 0;
      drain();
      check_counts("overflow");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
